// File: rtl/ingress_voq.sv
// ingress_voq: ingress port with EGRESS_CNT virtual output queues in one shared memory,
// registered per-queue flags and saturating accept/drop statistics per experiment run.
`default_nettype none

module ingress_voq #(
    parameter  int EGRESS_CNT  = 4,
    parameter  int QUEUE_DEPTH = 256,
    parameter  int META_WIDTH  = 32,
    parameter  int PORT_LSB    = 28,
    parameter  int CNT_WIDTH   = 16,
    localparam int SEL_W       = $clog2(EGRESS_CNT),
    localparam int PTR_W       = $clog2(QUEUE_DEPTH),
    localparam int OCC_W       = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [META_WIDTH-1:0]       ingress_in,
    input  logic                        ingress_in_en,
    input  logic                        experimenting,
    input  logic                        sched_en,
    input  logic [SEL_W-1:0]            sched_sel,
    output logic [META_WIDTH-1:0]       ingress_out,
    output logic                        ingress_out_en,
    output logic [EGRESS_CNT-1:0]       is_empty,
    output logic [EGRESS_CNT-1:0]       is_full,
    output logic [EGRESS_CNT*OCC_W-1:0] occupancy,
    output logic [CNT_WIDTH-1:0]        drop_cnt,
    output logic [CNT_WIDTH-1:0]        accept_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(QUEUE_DEPTH);

    logic [META_WIDTH-1:0] mem [EGRESS_CNT*QUEUE_DEPTH];
    logic [PTR_W-1:0]      head [EGRESS_CNT];
    logic [PTR_W-1:0]      tail [EGRESS_CNT];
    logic [OCC_W-1:0]      count [EGRESS_CNT];
    logic [OCC_W-1:0]      count_next [EGRESS_CNT];

    logic [SEL_W-1:0] enq_q;
    logic             enq_req;
    logic             enq_ok;
    logic             enq_drop;
    logic             deq_ok;
    logic             exp_d;
    logic             exp_rise;

    // Accept/drop and dequeue decisions use only the registered flags, so a
    // same-cycle dequeue never rescues a full queue and an empty queue never bypasses.
    assign enq_q    = ingress_in[PORT_LSB +: SEL_W];
    assign enq_req  = ingress_in_en && experimenting;
    assign enq_ok   = enq_req && !is_full[enq_q];
    assign enq_drop = enq_req && is_full[enq_q];
    assign deq_ok   = sched_en && !is_empty[sched_sel];
    assign exp_rise = experimenting && !exp_d;

    always_comb begin
        for (int q = 0; q < EGRESS_CNT; q++) begin
            count_next[q] = count[q];
            if (enq_ok && (enq_q == SEL_W'(q)))
                count_next[q] = count_next[q] + OCC_W'(1);
            if (deq_ok && (sched_sel == SEL_W'(q)))
                count_next[q] = count_next[q] - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int q = 0; q < EGRESS_CNT; q++) begin
                head[q]  <= '0;
                tail[q]  <= '0;
                count[q] <= '0;
            end
            is_empty <= '1;
            is_full  <= '0;
        end else begin
            for (int q = 0; q < EGRESS_CNT; q++) begin
                count[q]    <= count_next[q];
                is_empty[q] <= (count_next[q] == '0);
                is_full[q]  <= (count_next[q] == OCC_FULL);
            end
            if (enq_ok)
                tail[enq_q] <= tail[enq_q] + PTR_W'(1);
            if (deq_ok)
                head[sched_sel] <= head[sched_sel] + PTR_W'(1);
        end
    end

    // Storage carries no reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (enq_ok)
            mem[{enq_q, tail[enq_q]}] <= ingress_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ingress_out    <= '0;
            ingress_out_en <= 1'b0;
        end else begin
            ingress_out_en <= deq_ok;
            if (deq_ok)
                ingress_out <= mem[{sched_sel, head[sched_sel]}];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_d      <= 1'b0;
            accept_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            exp_d <= experimenting;
            if (exp_rise) begin
                accept_cnt <= enq_ok   ? CNT_WIDTH'(1) : '0;
                drop_cnt   <= enq_drop ? CNT_WIDTH'(1) : '0;
            end else begin
                if (enq_ok && (accept_cnt != CNT_MAX))
                    accept_cnt <= accept_cnt + CNT_WIDTH'(1);
                if (enq_drop && (drop_cnt != CNT_MAX))
                    drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    for (genvar g = 0; g < EGRESS_CNT; g++) begin : g_occ
        assign occupancy[g*OCC_W +: OCC_W] = count[g];
    end

endmodule

`default_nettype wire

// File: tb/tb_ingress_voq.sv
// tb_ingress_voq: directed self-checking bench for ingress_voq at default parameters.
`default_nettype none

module tb_ingress_voq;

    localparam int OCC_W = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ingress_in;
    logic        ingress_in_en;
    logic        experimenting;
    logic        sched_en;
    logic [1:0]  sched_sel;
    logic [31:0] ingress_out;
    logic        ingress_out_en;
    logic [3:0]  is_empty;
    logic [3:0]  is_full;
    logic [4*OCC_W-1:0] occupancy;
    logic [15:0] drop_cnt;
    logic [15:0] accept_cnt;

    int vectors     = 0;
    int miscompares = 0;

    ingress_voq dut (
        .clk            (clk),
        .reset          (reset),
        .ingress_in     (ingress_in),
        .ingress_in_en  (ingress_in_en),
        .experimenting  (experimenting),
        .sched_en       (sched_en),
        .sched_sel      (sched_sel),
        .ingress_out    (ingress_out),
        .ingress_out_en (ingress_out_en),
        .is_empty       (is_empty),
        .is_full        (is_full),
        .occupancy      (occupancy),
        .drop_cnt       (drop_cnt),
        .accept_cnt     (accept_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("miscompare at %s", tag);
        end
    endtask

    function automatic logic [OCC_W-1:0] occ(input int q);
        return occupancy[q*OCC_W +: OCC_W];
    endfunction

    initial begin
        reset = 1'b0; experimenting = 1'b0; ingress_in = '0; ingress_in_en = 1'b0;
        sched_en = 1'b0; sched_sel = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("rst_empty",  is_empty, 4'b1111);
        check("rst_full",   is_full, 4'b0000);
        check("rst_out_en", ingress_out_en, 1'b0);
        check("rst_out",    ingress_out, 32'h0);
        check("rst_occ",    occupancy, '0);
        check("rst_drop",   drop_cnt, 16'd0);
        check("rst_acc",    accept_cnt, 16'd0);

        // basic enqueue to q1/q2, dequeue q1
        experimenting = 1'b1;
        tick();
        ingress_in_en = 1'b1; ingress_in = 32'h1000_0001; tick();
        ingress_in = 32'h2000_0002; tick();
        ingress_in_en = 1'b0;
        check("enq_empty", is_empty, 4'b1001);
        check("enq_occ1",  occ(1), 9'd1);
        sched_en = 1'b1; sched_sel = 2'd1; tick();
        sched_en = 1'b0;
        check("deq1_en",    ingress_out_en, 1'b1);
        check("deq1_data",  ingress_out, 32'h1000_0001);
        check("deq1_empty", is_empty, 4'b1011);
        check("deq1_acc",   accept_cnt, 16'd2);
        tick();
        check("deq1_strobe_once", ingress_out_en, 1'b0);
        check("deq1_hold",        ingress_out, 32'h1000_0001);

        // new run, fill q3 to the brim plus one drop
        experimenting = 1'b0; tick();
        experimenting = 1'b1; tick();
        check("run_clr_acc", accept_cnt, 16'd0);
        ingress_in_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ingress_in = 32'h3000_0000 + i;
            if (i == 255) begin
                check("q3_occ255",  occ(3), 9'd255);
                check("q3_notfull", is_full, 4'b0000);
            end
            tick();
        end
        ingress_in = 32'h3000_0100; tick();
        ingress_in_en = 1'b0;
        check("q3_full",     is_full, 4'b1000);
        check("q3_occ256",   occ(3), 9'd256);
        check("q3_drop",     drop_cnt, 16'd1);
        check("q3_acc",      accept_cnt, 16'd256);
        check("q2_retained", occ(2), 9'd1);

        // drain q3 back to back
        sched_en = 1'b1; sched_sel = 2'd3;
        for (int i = 0; i < 256; i++) begin
            tick();
            check("drain_en",   ingress_out_en, 1'b1);
            check("drain_data", ingress_out, 32'h3000_0000 + i);
        end
        sched_en = 1'b0;
        check("drain_empty", is_empty[3], 1'b1);
        check("drain_full",  is_full, 4'b0000);
        tick();
        check("drain_idle", ingress_out_en, 1'b0);

        // grant on empty q0
        sched_en = 1'b1; sched_sel = 2'd0; tick();
        sched_en = 1'b0;
        check("empty_grant_en",   ingress_out_en, 1'b0);
        check("empty_grant_hold", ingress_out, 32'h3000_00FF);
        check("empty_grant_occ0", occ(0), 9'd0);

        // same-cycle enqueue/dequeue on q2 holding 5
        ingress_in_en = 1'b1;
        for (int i = 3; i <= 6; i++) begin
            ingress_in = 32'h2000_0000 + i;
            tick();
        end
        check("q2_occ5", occ(2), 9'd5);
        ingress_in = 32'h2000_0007; sched_en = 1'b1; sched_sel = 2'd2; tick();
        check("q2_sim_occ",  occ(2), 9'd5);
        check("q2_sim_en",   ingress_out_en, 1'b1);
        check("q2_sim_data", ingress_out, 32'h2000_0002);

        // same-cycle enqueue/dequeue on empty q0: no bypass
        ingress_in = 32'h0000_0009; sched_sel = 2'd0; tick();
        ingress_in_en = 1'b0;
        check("q0_nobypass_en",  ingress_out_en, 1'b0);
        check("q0_nobypass_occ", occ(0), 9'd1);
        tick();
        sched_en = 1'b0;
        check("q0_next_en",   ingress_out_en, 1'b1);
        check("q0_next_data", ingress_out, 32'h0000_0009);
        check("acc_262",      accept_cnt, 16'd262);

        // gating by experimenting
        experimenting = 1'b0; ingress_in_en = 1'b1; ingress_in = 32'h1000_0055; tick();
        ingress_in_en = 1'b0;
        check("gated_occ1", occ(1), 9'd0);
        check("gated_acc",  accept_cnt, 16'd262);
        experimenting = 1'b1; tick();
        check("rise_clr_acc",  accept_cnt, 16'd0);
        check("rise_clr_drop", drop_cnt, 16'd0);

        // refill q3 and collect 7 drops
        ingress_in_en = 1'b1;
        for (int i = 0; i < 263; i++) begin
            ingress_in = 32'h3000_0000 + i;
            tick();
        end
        ingress_in_en = 1'b0;
        check("drop7",  drop_cnt, 16'd7);
        check("acc256", accept_cnt, 16'd256);

        // rising edge coincident with a drop counts it as 1
        experimenting = 1'b0; tick();
        experimenting = 1'b1; ingress_in_en = 1'b1; ingress_in = 32'h3000_0AAA; tick();
        ingress_in_en = 1'b0;
        check("rise_drop1", drop_cnt, 16'd1);
        check("rise_acc0",  accept_cnt, 16'd0);
        experimenting = 1'b0; tick();
        experimenting = 1'b1; tick();
        check("toggle_drop0",  drop_cnt, 16'd0);
        check("toggle_acc0",   accept_cnt, 16'd0);
        check("toggle_keep3",  occ(3), 9'd256);
        check("toggle_keep2",  occ(2), 9'd5);
        check("toggle_full",   is_full, 4'b1000);

        // asynchronous reset mid-stream
        reset = 1'b0; #2;
        check("arst_empty", is_empty, 4'b1111);
        check("arst_full",  is_full, 4'b0000);
        check("arst_occ",   occupancy, '0);
        check("arst_drop",  drop_cnt, 16'd0);
        check("arst_out",   ingress_out, 32'h0);
        sched_en = 1'b1; sched_sel = 2'd2;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("post_rst_en0", ingress_out_en, 1'b0);
        tick();
        check("post_rst_en1", ingress_out_en, 1'b0);
        sched_en = 1'b0;
        ingress_in_en = 1'b1; ingress_in = 32'h2000_0ABC; tick();
        ingress_in_en = 1'b0;
        check("post_rst_occ", occ(2), 9'd1);
        check("post_rst_acc", accept_cnt, 16'd1);
        sched_en = 1'b1; sched_sel = 2'd2; tick();
        sched_en = 1'b0;
        check("post_rst_deq_en",   ingress_out_en, 1'b1);
        check("post_rst_deq_data", ingress_out, 32'h2000_0ABC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
